// File: rtl/sr_cmd_pkg.sv
// -----------------------------------------------------------------------------
// sr_cmd_pkg
// Shared types and helpers for the SR flip-flop command arbiter.
//   sr_state_e : arbiter FSM states (IDLE, DRIVE, CHECK)
//   OP_SET     : command opcode that pulses S on the target flag
//   OP_RST     : command opcode that pulses R on the target flag
//   sr_clog2   : ceil(log2(value)), never less than 1, for index widths
// Optional feature macro: SR_CMD_CHECK_EN (see sr_cmd_arbiter).
// -----------------------------------------------------------------------------
package sr_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } sr_state_e;

  localparam logic OP_SET = 1'b1;
  localparam logic OP_RST = 1'b0;

  // A width of at least one bit keeps single-entry index ports legal.
  function automatic int sr_clog2(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/sr_cmd_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker. The search starts at ptr and wraps at N,
// so the requester at ptr has the highest priority this cycle.
// Ports:
//   req   in  N   request vector
//   ptr   in  IW  index searched first
//   grant out N   one-hot grant (zero when req is zero)
//   idx   out IW  encoded index of the granted requester (0 when none)
// -----------------------------------------------------------------------------
module rr_arbiter
  import sr_cmd_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = sr_clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/sr_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// sr_cmd_arbiter
// Lets NUM_REQ agents share a bank of NUM_FLAGS external SR flip-flops. One
// command at a time is granted round-robin, turned into a single registered
// S or R strobe, optionally verified against the Q readback, then acked.
// S and R are never driven together because only one command is ever in
// flight and it targets exactly one bit of exactly one strobe vector.
//
// Ports:
//   clk        in   1               rising-edge clock
//   rst_n      in   1               asynchronous active-low reset
//   req_valid  in   NUM_REQ         command valid, held until ack
//   req_op     in   NUM_REQ         1 = set (S), 0 = reset (R)
//   req_flag   in   NUM_REQ*FLAG_W  target flag, requester i at [i*FLAG_W +: FLAG_W]
//   req_ack    out  NUM_REQ         one-cycle completion pulse, one-hot or zero
//   sr_s       out  NUM_FLAGS       registered S strobes
//   sr_r       out  NUM_FLAGS       registered R strobes
//   flag_q     in   NUM_FLAGS       Q readback from the SR bank
//   err_clr    in   1               clears the sticky error
//   err        out  1               sticky error flag
//   err_req    out  REQ_W           requester that caused the first error
//   busy       out  1               high whenever the FSM is not IDLE
//
// Optional feature macro SR_CMD_CHECK_EN:
//   defined   : IDLE -> DRIVE -> CHECK, ack in CHECK after comparing flag_q.
//   undefined : IDLE -> DRIVE, ack together with the strobe, flag_q ignored,
//               err only reports out-of-range flag indices.
// -----------------------------------------------------------------------------
module sr_cmd_arbiter
  import sr_cmd_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int NUM_FLAGS = 8,
  parameter int FLAG_W    = sr_clog2(NUM_FLAGS),
  parameter int REQ_W     = sr_clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_op,
  input  logic [NUM_REQ*FLAG_W-1:0]   req_flag,
  output logic [NUM_REQ-1:0]          req_ack,
  output logic [NUM_FLAGS-1:0]        sr_s,
  output logic [NUM_FLAGS-1:0]        sr_r,
  input  logic [NUM_FLAGS-1:0]        flag_q,
  input  logic                        err_clr,
  output logic                        err,
  output logic [REQ_W-1:0]            err_req,
  output logic                        busy
);

  sr_state_e           state;
  logic [REQ_W-1:0]    ptr;
  logic [REQ_W-1:0]    win_idx;
  logic [REQ_W-1:0]    next_ptr;
  logic                cmd_oor;

  logic [NUM_REQ-1:0]  gnt_onehot;
  logic [REQ_W-1:0]    gnt_idx;
  logic [FLAG_W-1:0]   flag_arr [NUM_REQ];
  logic                sel_op;
  logic [FLAG_W-1:0]   sel_flag;
  logic                sel_oor;

  logic                err_event;
  logic                err_set;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (REQ_W)
  ) u_rr (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (gnt_onehot),
    .idx   (gnt_idx)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      flag_arr[i] = req_flag[i*FLAG_W +: FLAG_W];
    end
  end

  assign sel_op   = |(req_op & gnt_onehot);
  assign sel_flag = flag_arr[gnt_idx];
  // Only reachable when NUM_FLAGS is not a power of two.
  assign sel_oor  = ({1'b0, sel_flag} >= (FLAG_W+1)'(NUM_FLAGS));

  assign next_ptr = (win_idx == REQ_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
  assign busy     = (state != IDLE);

`ifdef SR_CMD_CHECK_EN
  logic                cmd_op;
  logic [FLAG_W-1:0]   cmd_flag;
  logic [NUM_REQ-1:0]  win_onehot;
  logic                check_fail;

  assign win_onehot = NUM_REQ'(1) << win_idx;
  // An out-of-range command never indexes flag_q for its verdict.
  assign check_fail = cmd_oor ? 1'b1 : (flag_q[cmd_flag] != cmd_op);
  assign err_event  = (state == CHECK) && check_fail;
`else
  logic unused_flag_q;

  assign unused_flag_q = ^flag_q;
  assign err_event     = (state == DRIVE) && cmd_oor;
`endif

  // The first error is sticky; a coincident err_clr lets a new error replace it.
  assign err_set = err_event && (!err || err_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      win_idx  <= '0;
      cmd_oor  <= 1'b0;
      sr_s     <= '0;
      sr_r     <= '0;
      req_ack  <= '0;
      err      <= 1'b0;
      err_req  <= '0;
`ifdef SR_CMD_CHECK_EN
      cmd_op   <= OP_RST;
      cmd_flag <= '0;
`endif
    end else begin
      sr_s    <= '0;
      sr_r    <= '0;
      req_ack <= '0;

      if (err_set) begin
        err     <= 1'b1;
        err_req <= win_idx;
      end else if (err_clr) begin
        err     <= 1'b0;
        err_req <= '0;
      end

      case (state)
        IDLE: begin
          if (|req_valid) begin
            state   <= DRIVE;
            win_idx <= gnt_idx;
            cmd_oor <= sel_oor;
`ifdef SR_CMD_CHECK_EN
            cmd_op   <= sel_op;
            cmd_flag <= sel_flag;
`else
            req_ack  <= gnt_onehot;
`endif
            // Strobes are loaded on the way into DRIVE so they are visible
            // for exactly the DRIVE cycle.
            if (!sel_oor) begin
              sr_s[sel_flag] <= (sel_op == OP_SET);
              sr_r[sel_flag] <= (sel_op == OP_RST);
            end
          end
        end
        DRIVE: begin
`ifdef SR_CMD_CHECK_EN
          state   <= CHECK;
          req_ack <= win_onehot;
`else
          state   <= IDLE;
          ptr     <= next_ptr;
`endif
        end
`ifdef SR_CMD_CHECK_EN
        CHECK: begin
          state <= IDLE;
          ptr   <= next_ptr;
        end
`endif
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
